// File: rtl/serial_sub16_pkg.sv
// Shared definitions for the serial adder/subtractor family: default sizes,
// derived slice count and FSM state encoding.
package serial_sub16_pkg;

  localparam int unsigned WIDTH_DEF  = 16;
  localparam int unsigned DIGIT_DEF  = 4;
  localparam int unsigned SLICES_DEF = WIDTH_DEF / DIGIT_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub16_sub_slice.sv
// Combinational DIGIT-bit subtract with borrow chaining: d = a - b - bin.
module sub_slice #(
  parameter int unsigned DIGIT = serial_sub16_pkg::DIGIT_DEF
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             bin,
  output logic [DIGIT-1:0] d_c,
  output logic             bout_c
);

  logic [DIGIT:0] full_c;

  // The extra top bit becomes 1 exactly when a < b + bin.
  assign full_c = {1'b0, a} - {1'b0, b} - (DIGIT+1)'(bin);
  assign d_c    = full_c[DIGIT-1:0];
  assign bout_c = full_c[DIGIT];

endmodule

// File: rtl/serial_sub16.sv
// Digit-serial two's-complement subtractor with valid/ready handshakes on
// both sides; one DIGIT-bit slice per cycle, LSB slice first.
module serial_sub16
  import serial_sub16_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DIGIT = DIGIT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Ovf
);

  localparam int unsigned SLICES = WIDTH / DIGIT;
  localparam int unsigned CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_sh, b_sh, diff_r;
  logic             borrow, a_msb, b_msb, bout_r, ovf_r;
  logic [DIGIT-1:0] d_c;
  logic             bo_c;
  logic             last_c;

  sub_slice #(.DIGIT(DIGIT)) u_slice (
    .a      (a_sh[DIGIT-1:0]),
    .b      (b_sh[DIGIT-1:0]),
    .bin    (borrow),
    .d_c    (d_c),
    .bout_c (bo_c)
  );

  assign last_c = (cnt == CNT_W'(SLICES - 1));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid)  state_nx = CALC;
      CALC:    if (last_c)    state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand capture, slice shifting and result accumulation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      a_sh   <= '0;
      b_sh   <= '0;
      diff_r <= '0;
      borrow <= 1'b0;
      a_msb  <= 1'b0;
      b_msb  <= 1'b0;
      bout_r <= 1'b0;
      ovf_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh   <= A;
            b_sh   <= B;
            borrow <= Bin;
            a_msb  <= A[WIDTH-1];
            b_msb  <= B[WIDTH-1];
            cnt    <= '0;
          end
        end
        CALC: begin
          a_sh   <= a_sh >> DIGIT;
          b_sh   <= b_sh >> DIGIT;
          borrow <= bo_c;
          diff_r <= {d_c, diff_r[WIDTH-1:DIGIT]};
          cnt    <= cnt + CNT_W'(1);
          // The final slice carries the result MSB, so flags resolve here.
          if (last_c) begin
            bout_r <= bo_c;
            ovf_r  <= (a_msb != b_msb) && (d_c[DIGIT-1] != a_msb);
          end
        end
        default: ;
      endcase
    end
  end

  assign Diff = diff_r;
  assign Bout = bout_r;
  assign Ovf  = ovf_r;

endmodule
